// File: rtl/apb_slave_regfile.sv
// Purpose  : APB completer register file of NREGS 32-bit words; the top word is a read-only ID.
// Latency  : Pready rises in the first access cycle, or after WAIT_CYCLES stalls when APB_SLV_WAIT_EN is defined.
// Backpress: Pready is held low during wait states; dropping Pselx in ACCESS aborts with no write.
//
// Ports:
//   Hclk, Hrstn        clock and synchronous active-low reset (rising edge)
//   Pselx, Penable     APB select and access-phase strobe from the bridge
//   Pwrite             1 = write, 0 = read
//   Paddr, Pwdata      byte address and write data; both sampled in the setup phase only
//   Prdata             read data; zero unless Pready=1
//   Pready, Pslverr    transfer complete and error response; Pslverr is zero unless Pready=1
//
// Build option: APB_SLV_WAIT_EN enables the wait-state counter.
// Without it, the slave completes with zero wait states.

module apb_slave_regfile #(
  parameter int unsigned NREGS       = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        Hclk,
  input  logic        Hrstn,
  input  logic        Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam int unsigned IW = $clog2(NREGS);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] lat_idx;
  logic          lat_write;
  logic [31:0]   lat_wdata;
  logic          lat_bad_addr;
  logic [31:0]   regs [NREGS];
  logic          setup;
  logic          cnt_done;
  logic          err;
  logic          commit;
  logic [31:0]   rd_val;

  assign setup = Pselx & ~Penable;

`ifdef APB_SLV_WAIT_EN
  logic [3:0] cnt;

  // Counter restarts at every setup and saturates at WAIT_CYCLES.
  // It holds its value if the bridge idles Penable while in ACCESS.
  always_ff @(posedge Hclk) begin
    if (!Hrstn) begin
      cnt <= '0;
    end else if (state_q == IDLE && setup) begin
      cnt <= '0;
    end else if (state_q == ACCESS && Pselx && Penable && cnt != WAIT_CYCLES[3:0]) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign cnt_done = (cnt == WAIT_CYCLES[3:0]);
`else
  // This is a zero-wait slave, so the effective wait count is zero.
  localparam int unsigned EFF_WAIT = WAIT_CYCLES * 0;
  assign cnt_done = (EFF_WAIT == 0);
`endif

  assign Pready = (state_q == ACCESS) & Pselx & Penable & cnt_done;

  // A write to the ID word is refused.
  // It is reported the same way as a bad address.
  assign err    = lat_bad_addr | (lat_write & (lat_idx == IW'(NREGS - 1)));
  assign commit = Pready & lat_write & ~err;

  assign rd_val  = (lat_idx == IW'(NREGS - 1)) ? ID_VALUE : regs[lat_idx];
  assign Prdata  = (Pready & ~err & ~lat_write) ? rd_val : 32'h0;
  assign Pslverr = Pready & err;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // Penable without a preceding setup is ignored here.
        if (setup) state_d = ACCESS;
      end
      ACCESS: begin
        if (!Pselx)      state_d = IDLE;
        else if (Pready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hrstn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Reset takes priority, so a transfer in flight never commits.
  always_ff @(posedge Hclk) begin
    if (!Hrstn) begin
      lat_idx      <= '0;
      lat_write    <= 1'b0;
      lat_wdata    <= '0;
      lat_bad_addr <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      if (state_q == IDLE && setup) begin
        lat_idx      <= Paddr[IW+1:2];
        lat_write    <= Pwrite;
        lat_wdata    <= Pwdata;
        lat_bad_addr <= (Paddr[1:0] != 2'b00) | (Paddr[31:IW+2] != '0);
      end
      if (commit) regs[lat_idx] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

  localparam int NREGS = 16;
  localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_SLV_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic        Hclk = 1'b0;
  logic        Hrstn;
  logic        Pselx, Penable, Pwrite;
  logic [31:0] Paddr, Pwdata;
  logic [31:0] Prdata;
  logic        Pready, Pslverr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [NREGS];

  always #5 Hclk = ~Hclk;

  apb_slave_regfile #(.NREGS(NREGS), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut (
    .Hclk(Hclk), .Hrstn(Hrstn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Enter at posedge+1 and leave at posedge+1 after the completing edge.
  // This lets consecutive calls run back-to-back.
  // Paddr and Pwdata are scrambled during the access phase to confirm they are ignored.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic slverr, output int waits);
    bit done;
    Pselx = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = wdata;
    @(negedge Hclk);
    check_eq("setup_pready", {31'b0, Pready}, 32'd0);
    @(posedge Hclk); #1;
    Penable = 1'b1; Paddr = $urandom; Pwdata = $urandom;
    waits = 0; done = 1'b0; rdata = '0; slverr = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge Hclk);
      if (Pready) begin
        done = 1'b1; rdata = Prdata; slverr = Pslverr;
      end else begin
        waits++;
        check_eq("wait_prdata", Prdata, 32'd0);
        check_eq("wait_slverr", {31'b0, Pslverr}, 32'd0);
      end
      @(posedge Hclk); #1;
    end
    check_eq("xfer_timeout_done", {31'b0, done}, 32'd1);
    Pselx = 1'b0; Penable = 1'b0;
  endtask

  task automatic do_check(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rd; logic se; int w;
    xfer(wr, addr, wdata, rd, se, w);
    check_eq({tag, "_waits"}, 32'(w), 32'(WAITS));
    check_eq({tag, "_slverr"}, {31'b0, se}, {31'b0, exp_err});
    if (!wr) check_eq({tag, "_prdata"}, rd, exp_rd);
  endtask

  // Reference rules: the address must be aligned and inside NREGS*4 bytes.
  // The ID word is read-only.
  function automatic bit ref_err(input bit wr, input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= NREGS * 4) || (wr && (addr / 4 == NREGS - 1));
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    if (ref_err(1'b0, addr)) return 32'h0;
    if (addr / 4 == NREGS - 1) return ID;
    return model[addr / 4];
  endfunction

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    bit wr;

    vecs[0]  = '{0, 32'h00, 32'h0,        32'h0,        0};
    vecs[1]  = '{0, 32'h3C, 32'h0,        ID,           0};
    vecs[2]  = '{1, 32'h04, 32'h0000_00FF, 32'h0,       0};
    vecs[3]  = '{0, 32'h04, 32'h0,        32'h0000_00FF, 0};
    vecs[4]  = '{1, 32'h00, 32'hF,        32'h0,        0};
    vecs[5]  = '{1, 32'h04, 32'hF0,       32'h0,        0};
    vecs[6]  = '{1, 32'h08, 32'hF00,      32'h0,        0};
    vecs[7]  = '{0, 32'h00, 32'h0,        32'hF,        0};
    vecs[8]  = '{0, 32'h04, 32'h0,        32'hF0,       0};
    vecs[9]  = '{0, 32'h08, 32'h0,        32'hF00,      0};
    vecs[10] = '{1, 32'h3C, 32'hDEAD_BEEF, 32'h0,       1};
    vecs[11] = '{1, 32'h41, 32'h1234_5678, 32'h0,       1};
    vecs[12] = '{1, 32'h100, 32'hCAFE_F00D, 32'h0,      1};
    vecs[13] = '{0, 32'h3C, 32'h0,        ID,           0};
    vecs[14] = '{0, 32'h00, 32'h0,        32'hF,        0};
    vecs[15] = '{0, 32'h04, 32'h0,        32'hF0,       0};
    vecs[16] = '{0, 32'h08, 32'h0,        32'hF00,      0};
    vecs[17] = '{0, 32'h40, 32'h0,        32'h0,        1};
    vecs[18] = '{0, 32'h0C, 32'h0,        32'h0,        0};
    vecs[19] = '{0, 32'h02, 32'h0,        32'h0,        1};

    Hrstn = 1'b0; Pselx = 1'b0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;

    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    check_eq("rst_prdata", Prdata, 32'd0);
    check_eq("rst_pready", {31'b0, Pready}, 32'd0);
    check_eq("rst_pslverr", {31'b0, Pslverr}, 32'd0);
    @(posedge Hclk); #1;
    Hrstn = 1'b1;

    // Directed table, issued back-to-back.
    for (int i = 0; i < 20; i++) begin
      do_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rd, vecs[i].exp_err);
      if (vecs[i].wr && !vecs[i].exp_err) model[vecs[i].addr / 4] = vecs[i].wdata;
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      wr  = 1'($urandom_range(0, 1));
      d   = $urandom;
      case (sel)
        6:       a = (NREGS - 1) * 4;
        7:       a = ($urandom_range(0, NREGS - 1) * 4) + $urandom_range(1, 3);
        8:       a = NREGS * 4 + $urandom_range(0, 1000);
        default: a = $urandom_range(0, NREGS - 1) * 4;
      endcase
      do_check("rand", wr, a, d, ref_read(a), ref_err(wr, a));
      if (wr && !ref_err(wr, a)) model[a / 4] = d;
      repeat ($urandom_range(0, 2)) begin @(posedge Hclk); #1; end
    end

    // Abort: Pselx drops during the access phase, so the write must not land.
    Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h14; Pwdata = 32'h5555_AAAA;
    @(posedge Hclk); #1;
    if (WAITS > 0) begin
      Penable = 1'b1;
      @(negedge Hclk);
      check_eq("abort_wait_pready", {31'b0, Pready}, 32'd0);
      @(posedge Hclk); #1;
    end
    Pselx = 1'b0; Penable = 1'b0;
    @(negedge Hclk);
    check_eq("abort_pready", {31'b0, Pready}, 32'd0);
    @(posedge Hclk); #1;
    do_check("abort_readback", 1'b0, 32'h14, 32'h0, model[5], 1'b0);

    // Penable without setup: the slave must stay idle and must not write.
    Pselx = 1'b1; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h18; Pwdata = 32'h77;
    for (int c = 0; c < 3; c++) begin
      @(negedge Hclk);
      check_eq("nosetup_pready", {31'b0, Pready}, 32'd0);
      @(posedge Hclk); #1;
    end
    Pselx = 1'b0; Penable = 1'b0;
    do_check("nosetup_readback", 1'b0, 32'h18, 32'h0, model[6], 1'b0);

    // Reset mid-access: the outputs go quiet and all registers clear.
    Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h1C; Pwdata = 32'h1234;
    @(posedge Hclk); #1;
    Penable = 1'b1; Hrstn = 1'b0;
    @(posedge Hclk); #1;
    @(negedge Hclk);
    check_eq("midrst_pready", {31'b0, Pready}, 32'd0);
    check_eq("midrst_prdata", Prdata, 32'd0);
    check_eq("midrst_pslverr", {31'b0, Pslverr}, 32'd0);
    @(posedge Hclk); #1;
    Pselx = 1'b0; Penable = 1'b0; Hrstn = 1'b1;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    do_check("midrst_reg7", 1'b0, 32'h1C, 32'h0, 32'h0, 1'b0);
    do_check("midrst_reg0", 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
    do_check("midrst_reg1", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);
    do_check("midrst_id", 1'b0, 32'h3C, 32'h0, ID, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
